// File: rtl/m_dm.sv
// m_dm: MEM-stage data memory.
// Stores are read-modify-write on the rising edge. Loads are combinational and
// sign- or zero-extended. Each committed store is reported on a registered
// write-log port one cycle later. Bad accesses raise err and never touch memory.
module m_dm #(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEMwrite,
  input  logic        MEMread,
  input  logic [31:0] MEMmode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        err,
  output logic        wr_valid,
  output logic [31:0] wr_pc,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    size;
  logic          zext;
  logic          misaligned;
  logic          out_of_range;
  logic          commit;
  logic [31:0]   old_word;
  logic [31:0]   word_d;

  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_pc_q, wr_pc_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  // Only the low three mode bits carry meaning.
  logic unused_mode;
  assign unused_mode = ^MEMmode[31:3];

  assign idx      = addr[AW+1:2];
  assign size     = MEMmode[1:0];
  assign zext     = MEMmode[2];
  assign old_word = mem_q[idx];

  // Access classification: alignment, range and reserved size.
  always_comb begin
    misaligned   = 1'b0;
    out_of_range = ({1'b0, addr} >= BYTE_LIMIT);
    case (size)
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      SZ_HALF: misaligned = addr[0];
      default: misaligned = 1'b0;
    endcase
    err    = (MEMread | MEMwrite) & (misaligned | out_of_range | (size == 2'b11));
    commit = MEMwrite & ~err & ~reset;
  end

  // Merge the store data into the currently stored word.
  always_comb begin
    word_d = old_word;
    case (size)
      SZ_WORD: word_d = wdata;
      SZ_HALF: begin
        if (addr[1]) word_d[31:16] = wdata[15:0];
        else         word_d[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        case (addr[1:0])
          2'd0:    word_d[7:0]   = wdata[7:0];
          2'd1:    word_d[15:8]  = wdata[7:0];
          2'd2:    word_d[23:16] = wdata[7:0];
          default: word_d[31:24] = wdata[7:0];
        endcase
      end
      default: word_d = old_word;
    endcase
  end

  // Load path: select lane from the pre-store word and extend.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    rdata = 32'd0;
    b = 8'd0;
    h = addr[1] ? old_word[31:16] : old_word[15:0];
    case (addr[1:0])
      2'd0:    b = old_word[7:0];
      2'd1:    b = old_word[15:8];
      2'd2:    b = old_word[23:16];
      default: b = old_word[31:24];
    endcase
    if (MEMread && !err) begin
      case (size)
        SZ_WORD: rdata = old_word;
        SZ_HALF: rdata = zext ? {16'd0, h} : {{16{h[15]}}, h};
        SZ_BYTE: rdata = zext ? {24'd0, b} : {{24{b[7]}}, b};
        default: rdata = 32'd0;
      endcase
    end
  end

  // Write-log next state: pulse on commit, otherwise hold the last record.
  always_comb begin
    wr_valid_d = commit;
    wr_pc_d    = commit ? pc                  : wr_pc_q;
    wr_addr_d  = commit ? {addr[31:2], 2'b00} : wr_addr_q;
    wr_data_d  = commit ? word_d              : wr_data_q;
  end

  // Memory array: cleared on reset, one word updated per committed store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'd0;
    end else if (commit) begin
      mem_q[idx] <= word_d;
    end
  end

  // Write-log registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_pc_q    <= 32'd0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_pc_q    <= wr_pc_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_pc    = wr_pc_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_m_dm.sv
// Testbench for m_dm: directed vectors, scoreboard queues checked by a monitor.
module tb_m_dm;

  localparam int unsigned DEPTH_WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEMwrite, MEMread;
  logic [31:0] MEMmode, addr, wdata, pc;
  logic [31:0] rdata;
  logic        err;
  logic        wr_valid;
  logic [31:0] wr_pc, wr_addr, wr_data;

  m_dm #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .reset(reset), .MEMwrite(MEMwrite), .MEMread(MEMread),
    .MEMmode(MEMmode), .addr(addr), .wdata(wdata), .pc(pc),
    .rdata(rdata), .err(err), .wr_valid(wr_valid), .wr_pc(wr_pc),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    bit          chk_wv;
    logic        wv;
    bit          chk_zero;
    string       name;
  } ld_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } wr_t;

  ld_t ld_q[$];
  wr_t wr_q[$];

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // Monitor: compare combinational outputs for this cycle and any log pulse.
  always @(negedge clk) begin
    if (mon_on) begin
      while (ld_q.size() > 0 && ld_q[0].cyc == cyc) begin
        ld_t e;
        e = ld_q.pop_front();
        check32({e.name, ".rdata"}, rdata, e.rdata);
        check32({e.name, ".err"}, {31'd0, err}, {31'd0, e.err});
        if (e.chk_wv) check32({e.name, ".wr_valid"}, {31'd0, wr_valid}, {31'd0, e.wv});
        if (e.chk_zero) begin
          check32({e.name, ".wr_pc"},   wr_pc,   32'd0);
          check32({e.name, ".wr_addr"}, wr_addr, 32'd0);
          check32({e.name, ".wr_data"}, wr_data, 32'd0);
        end
      end
      if (wr_valid) begin
        if (wr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_wr_valid: got wr_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check32({w.name, ".wr_pc"},   wr_pc,   w.pc);
          check32({w.name, ".wr_addr"}, wr_addr, w.addr);
          check32({w.name, ".wr_data"}, wr_data, w.data);
        end
      end
    end
  end

  task automatic op(input logic w, input logic r, input logic [2:0] mode,
                    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p);
    MEMwrite = w; MEMread = r; MEMmode = {29'h1555_5555, mode};
    addr = a; wdata = wd; pc = p;
  endtask

  task automatic exp_ld(input string name, input logic [31:0] rd, input logic e,
                        input bit cw, input logic wv, input bit cz);
    ld_t x;
    x.cyc = cyc; x.rdata = rd; x.err = e; x.chk_wv = cw; x.wv = wv;
    x.chk_zero = cz; x.name = name;
    ld_q.push_back(x);
  endtask

  task automatic exp_wr(input string name, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] d);
    wr_t x;
    x.pc = p; x.addr = a; x.data = d; x.name = name;
    wr_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    step();
    reset = 1'b0;
    mon_on = 1'b1;

    // 1: reset state
    op(1'b0, 1'b1, 3'd0, 32'h10, 32'd0, 32'd0);
    exp_ld("rst_lw10", 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();

    // 2: word store then load
    op(1'b1, 1'b0, 3'd0, 32'h20, 32'h12345678, 32'h100);
    exp_ld("sw20", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_wr("log_sw20", 32'h100, 32'h20, 32'h12345678);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h20, 32'd0, 32'h104);
    exp_ld("lw20", 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // 3: byte store and sub-word loads
    op(1'b1, 1'b0, 3'd2, 32'h21, 32'hCCDDEEAB, 32'h108);
    exp_wr("log_sb21", 32'h108, 32'h20, 32'h1234AB78);
    step();
    op(1'b0, 1'b1, 3'd2, 32'h21, 32'd0, 32'h10C);
    exp_ld("lb21", 32'hFFFFFFAB, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd6, 32'h21, 32'd0, 32'h110);
    exp_ld("lbu21", 32'h000000AB, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd1, 32'h22, 32'd0, 32'h114);
    exp_ld("lh22", 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd1, 32'h20, 32'd0, 32'h118);
    exp_ld("lh20", 32'hFFFFAB78, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd5, 32'h20, 32'd0, 32'h11C);
    exp_ld("lhu20", 32'h0000AB78, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b1, 1'b0, 3'd1, 32'h22, 32'h77778001, 32'h120);
    exp_wr("log_sh22", 32'h120, 32'h20, 32'h8001AB78);
    step();
    op(1'b0, 1'b1, 3'd1, 32'h22, 32'd0, 32'h124);
    exp_ld("lh22_neg", 32'hFFFF8001, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd2, 32'h23, 32'd0, 32'h128);
    exp_ld("lb23", 32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // 4: errors
    op(1'b1, 1'b0, 3'd0, 32'h22, 32'hDEADDEAD, 32'h12C);
    exp_ld("sw22_mis", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h20, 32'd0, 32'h130);
    exp_ld("lw20_unch", 32'h8001AB78, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd0, DEPTH_WORDS * 4, 32'd0, 32'h134);
    exp_ld("lw_oor", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b1, 1'b0, 3'd0, DEPTH_WORDS * 4 + 32'h20, 32'hBAD0BAD0, 32'h138);
    exp_ld("sw_oor_alias", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h20, 32'd0, 32'h13C);
    exp_ld("lw20_after_oor", 32'h8001AB78, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd1, 32'h21, 32'd0, 32'h140);
    exp_ld("lh21_mis", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd3, 32'h20, 32'd0, 32'h144);
    exp_ld("rsvd_mode", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd2, DEPTH_WORDS * 4 - 1, 32'd0, 32'h148);
    exp_ld("lb_top", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b0, 3'd0, 32'h23, 32'd0, 32'h14C);
    exp_ld("idle_mis", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b0, 3'd0, 32'h20, 32'd0, 32'h150);
    exp_ld("noread20", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // 5: read during write, same address
    op(1'b1, 1'b1, 3'd0, 32'h40, 32'hDEADBEEF, 32'h154);
    exp_ld("rdw40", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_wr("log_sw40", 32'h154, 32'h40, 32'hDEADBEEF);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h40, 32'd0, 32'h158);
    exp_ld("lw40", 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0);
    step();

    // back-to-back stores
    op(1'b1, 1'b0, 3'd0, 32'h44, 32'h00000001, 32'h15C);
    exp_wr("log_b2b_0", 32'h15C, 32'h44, 32'h00000001);
    step();
    op(1'b1, 1'b0, 3'd0, 32'h48, 32'h00000002, 32'h160);
    exp_wr("log_b2b_1", 32'h160, 32'h48, 32'h00000002);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h44, 32'd0, 32'h164);
    exp_ld("lw44", 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h48, 32'd0, 32'h168);
    exp_ld("lw48", 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0);
    step();

    // 6: reset mid-stream; store in the reset cycle is dropped
    op(1'b1, 1'b0, 3'd0, 32'h0, 32'hFFFFFFFF, 32'h200);
    exp_wr("log_sw0", 32'h200, 32'h0, 32'hFFFFFFFF);
    step();
    reset = 1'b1;
    op(1'b1, 1'b0, 3'd0, 32'h4, 32'h55555555, 32'h204);
    step();
    reset = 1'b0;
    op(1'b0, 1'b1, 3'd0, 32'h0, 32'd0, 32'h208);
    exp_ld("post_rst_lw0", 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h4, 32'd0, 32'h20C);
    exp_ld("post_rst_lw4", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h20, 32'd0, 32'h210);
    exp_ld("post_rst_lw20", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    op(1'b0, 1'b1, 3'd0, 32'h40, 32'd0, 32'h214);
    exp_ld("post_rst_lw40", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    step();
    step();

    n_total++;
    if (ld_q.size() == 0 && wr_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d load and %0d log entries pending, expected 0 and 0",
                  ld_q.size(), wr_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
